// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl
// Sequencer for the CPU memory-interface registers. It runs one instruction
// fetch, data load or data store per request. It drives the MAR/MDR/IR load
// enables and the MOV/RW/MOC memory handshake. The wait for MOC is bounded.
//
// Ports:
//   CLK     clock; all state changes on the rising edge
//   RSTn    asynchronous active-low reset
//   REQ     start request, sampled only in IDLE
//   OP[1:0] 00 fetch, 01 load, 10 store, 11 illegal (sampled with REQ)
//   MOC     memory operation complete
//   MARLd   MAR load enable
//   MDRLd   MDR load enable
//   MDRSel  MDR source select: 0 memory data, 1 datapath store data
//   IRLd    IR load enable
//   MOV     memory operation valid
//   RW      1 read, 0 write (meaningful while MOV=1)
//   BUSY    high in every state except IDLE
//   DONE    one-cycle completion pulse
//   ERR     with DONE: request was illegal or timed out
//   ERRCNT  saturating timeout counter
module mem_seq_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       REQ,
    input  logic [1:0] OP,
    input  logic       MOC,
    output logic       MARLd,
    output logic       MDRLd,
    output logic       MDRSel,
    output logic       IRLd,
    output logic       MOV,
    output logic       RW,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [7:0] ERRCNT
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        MEM,
        LATCH,
        FIN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       op_q;
    logic             err_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [7:0]       errcnt_q;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // This MEM cycle has no MOC and is the last one allowed.
    logic timeout_hit;
    assign timeout_hit = (state == MEM) && !MOC && (wait_cnt == WAIT_LAST);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        MARLd    = 1'b0;
        MDRLd    = 1'b0;
        MDRSel   = 1'b0;
        IRLd     = 1'b0;
        MOV      = 1'b0;
        RW       = 1'b0;
        DONE     = 1'b0;
        ERR      = 1'b0;
        case (state)
            IDLE: begin
                if (REQ) begin
                    state_nx = (OP == OP_ILL) ? FIN : ADDR;
                end
            end
            ADDR: begin
                MARLd = 1'b1;
                if (op_q == OP_STORE) begin
                    MDRLd  = 1'b1;
                    MDRSel = 1'b1;
                end
                state_nx = MEM;
            end
            MEM: begin
                MOV = 1'b1;
                RW  = (op_q != OP_STORE);
                if (MOC) begin
                    // Read data is captured into the MDR in the same cycle MOC arrives.
                    if (op_q != OP_STORE) begin
                        MDRLd = 1'b1;
                    end
                    state_nx = (op_q == OP_FETCH) ? LATCH : FIN;
                end else if (timeout_hit) begin
                    state_nx = FIN;
                end
            end
            LATCH: begin
                IRLd     = 1'b1;
                state_nx = FIN;
            end
            FIN: begin
                DONE     = 1'b1;
                ERR      = err_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            op_q     <= 2'b00;
            err_q    <= 1'b0;
            wait_cnt <= '0;
            errcnt_q <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ) begin
                        op_q  <= OP;
                        err_q <= (OP == OP_ILL);
                    end
                end
                ADDR: wait_cnt <= '0;
                MEM: begin
                    // The count stops at TIMEOUT, so it fits the counter width.
                    if (!MOC) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                    if (timeout_hit) begin
                        err_q    <= 1'b1;
                        errcnt_q <= sat_inc8(errcnt_q);
                    end
                end
                FIN:     err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign BUSY   = (state != IDLE);
    assign ERRCNT = errcnt_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Testbench for mem_seq_ctrl. The driver pushes the expected completion
// (error flag, ERRCNT, completion cycle) when it issues a request. A monitor
// pops the entry and compares it when DONE appears. Per-cycle output vectors
// {MARLd,MDRLd,MDRSel,IRLd,MOV,RW,BUSY} are checked along the way.
module tb_mem_seq_ctrl;

    localparam int TIMEOUT = 15;

    logic       CLK;
    logic       RSTn;
    logic       REQ;
    logic [1:0] OP;
    logic       MOC;
    logic       MARLd, MDRLd, MDRSel, IRLd, MOV, RW, BUSY, DONE, ERR;
    logic [7:0] ERRCNT;

    mem_seq_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .REQ    (REQ),
        .OP     (OP),
        .MOC    (MOC),
        .MARLd  (MARLd),
        .MDRLd  (MDRLd),
        .MDRSel (MDRSel),
        .IRLd   (IRLd),
        .MOV    (MOV),
        .RW     (RW),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .ERR    (ERR),
        .ERRCNT (ERRCNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [6:0] ov;
    assign ov = {MARLd, MDRLd, MDRSel, IRLd, MOV, RW, BUSY};

    typedef struct {
        logic       err;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] errcnt_m = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] sat8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic look(input string tag, input logic [6:0] exp);
        #1;
        chk(tag, {25'd0, ov}, {25'd0, exp});
    endtask

    // Completion expected 'lat' cycles after the next rising edge.
    task automatic expect_req(input logic err, input int lat);
        exp_t e;
        e.err = err;
        e.cnt = errcnt_m;
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (DONE) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_err", {31'd0, ERR}, {31'd0, e.err});
                chk("done_errcnt", {24'd0, ERRCNT}, {24'd0, e.cnt});
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_fetch();
        REQ = 1'b1; OP = 2'b00; MOC = 1'b0;
        expect_req(1'b0, 3);
        look("fetch_idle", 7'b0000000);
        step(); REQ = 1'b0; MOC = 1'b1;
        look("fetch_addr", 7'b1000001);
        step();
        look("fetch_mem", 7'b0100111);
        step(); MOC = 1'b0;
        look("fetch_latch", 7'b0001001);
        step();
        look("fetch_fin", 7'b0000001);
        step();
        look("fetch_idle_after", 7'b0000000);
    endtask

    task automatic run_timeout(input bit detail);
        REQ = 1'b1; OP = 2'b01; MOC = 1'b0;
        errcnt_m = sat8(errcnt_m);
        expect_req(1'b1, TIMEOUT + 1);
        step(); REQ = 1'b0;
        if (detail) look("to_addr", 7'b1000001);
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            if (detail) look("to_mem", 7'b0000111);
        end
        step();
        if (detail) look("to_fin", 7'b0000001);
        step();
    endtask

    initial begin
        RSTn = 1'b0; REQ = 1'b0; OP = 2'b00; MOC = 1'b0;
        #12;
        chk("rst_outs", {25'd0, ov}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_err", {31'd0, ERR}, 32'd0);
        chk("rst_errcnt", {24'd0, ERRCNT}, 32'd0);
        @(negedge CLK) RSTn = 1'b1;
        step();

        run_fetch();

        // Store with three MOC wait cycles.
        REQ = 1'b1; OP = 2'b10; MOC = 1'b0;
        expect_req(1'b0, 2 + 3);
        look("st_idle", 7'b0000000);
        step(); REQ = 1'b0;
        look("st_addr", 7'b1110001);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) MOC = 1'b1;
            look("st_mem", 7'b0000101);
        end
        step(); MOC = 1'b0;
        look("st_fin", 7'b0000001);
        step();

        run_timeout(1'b1);
        chk("errcnt_first", {24'd0, ERRCNT}, 32'd1);

        // MOC in the last allowed MEM cycle is a success.
        REQ = 1'b1; OP = 2'b01; MOC = 1'b0;
        expect_req(1'b0, 2 + (TIMEOUT - 1));
        step(); REQ = 1'b0;
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            if (i == TIMEOUT - 1) begin
                MOC = 1'b1;
                look("bd_mem_last", 7'b0100111);
            end else begin
                look("bd_mem", 7'b0000111);
            end
        end
        step(); MOC = 1'b0;
        look("bd_fin", 7'b0000001);
        chk("bd_errcnt", {24'd0, ERRCNT}, {24'd0, errcnt_m});
        step();

        // Illegal OP, with REQ held high through FIN.
        REQ = 1'b1; OP = 2'b11;
        expect_req(1'b1, 0);
        look("il_idle", 7'b0000000);
        step();
        look("il_fin", 7'b0000001);
        expect_req(1'b1, 1);
        step();
        look("il_idle_req_held", 7'b0000000);
        step(); REQ = 1'b0;
        look("il_fin2", 7'b0000001);
        step();
        look("il_idle_after", 7'b0000000);

        for (int i = 0; i < 255; i++) run_timeout(1'b0);
        chk("errcnt_sat", {24'd0, ERRCNT}, 32'd255);

        // Async reset in the middle of MEM.
        REQ = 1'b1; OP = 2'b00; MOC = 1'b0;
        expect_req(1'b0, 3);
        step(); REQ = 1'b0;
        step();
        look("rst_mem", 7'b0000111);
        RSTn = 1'b0;
        sb.delete();
        errcnt_m = 8'd0;
        look("rst_async_outs", 7'b0000000);
        chk("rst_async_errcnt", {24'd0, ERRCNT}, 32'd0);
        step();
        look("rst_held", 7'b0000000);
        @(negedge CLK) RSTn = 1'b1;
        step();
        run_fetch();

        repeat (3) step();
        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
